// File: rtl/pipeline_hazard_controller.sv
// Hazard and stall sequencer for the F/D/E/M/W pipeline: operand forwarding,
// load-use stalls, branch flushes and a data-memory handshake FSM with watchdog.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemAccessM,
    input  logic             dmem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             dmem_req,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TMO = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    mem_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              req_c;
    logic              mem_stall;
    logic              lw_stall;

    // M-stage result is newer than W-stage, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m,
                                           input logic [4:0] rd_m,
                                           input logic       wr_w,
                                           input logic [4:0] rd_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
        if (v >= TMO)
            return TMO;
        else
            return v + WCNT_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        req_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_c = MemAccessM;
                if (MemAccessM && !dmem_ready) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end
            end
            S_WAIT: begin
                req_c  = 1'b1;
                wcnt_d = sat_inc(wcnt_q);
                if (dmem_ready)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if ((state_q == S_WAIT) && (wcnt_d == TMO))
            err_d = 1'b1;
    end

    assign mem_stall = req_c && !dmem_ready;
    assign lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Every control output is held inactive while reset is asserted.
    assign ForwardAE = rst ? 2'b00 : fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign ForwardBE = rst ? 2'b00 : fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    assign StallF    = !rst && (mem_stall || lw_stall);
    assign StallD    = !rst && (mem_stall || lw_stall);
    assign StallE    = !rst && mem_stall;
    assign StallM    = !rst && mem_stall;
    assign StallW    = !rst && mem_stall;
    assign FlushD    = !rst && PCSrcE && !mem_stall;
    assign FlushE    = !rst && (lw_stall || PCSrcE) && !mem_stall;
    assign dmem_req  = !rst && req_c;

    assign stall_cnt_d = stall_cnt_q + CNT_W'(StallF);
    assign flush_cnt_d = flush_cnt_q + CNT_W'(FlushD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout_err = err_q;
    assign stall_cycles    = stall_cnt_q;
    assign flush_events    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with MEM_TIMEOUT=4.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemAccessM, dmem_ready;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic        dmem_req, mem_timeout_err;
    logic [31:0] stall_cycles, flush_events;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE),
        .dmem_req(dmem_req), .mem_timeout_err(mem_timeout_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemAccessM = 0; dmem_ready = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        // Reset: outputs forced inactive even with hazard-producing inputs
        #2;
        PCSrcE = 1; MemAccessM = 1; RegWriteM = 1; RdM = 5; Rs1E = 5;
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
        #1;
        chk("rst_fwdA", ForwardAE, 2'b00);
        chk("rst_stallF", StallF, 0);
        chk("rst_stallE", StallE, 0);
        chk("rst_flushD", FlushD, 0);
        chk("rst_flushE", FlushE, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_err", mem_timeout_err, 0);
        chk("rst_scnt", stall_cycles, 0);
        chk("rst_fcnt", flush_events, 0);
        clear_inputs();
        @(negedge clk); rst = 1'b0;

        // Forwarding
        tick();
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
        #1;
        chk("fwd_A_M", ForwardAE, 2'b10);
        chk("fwd_B_none", ForwardBE, 2'b00);
        RegWriteM = 0;
        #1;
        chk("fwd_A_W", ForwardAE, 2'b01);
        RegWriteM = 1; Rs2E = 5;
        #1;
        chk("fwd_B_M", ForwardBE, 2'b10);
        RdM = 0; RdW = 0; Rs1E = 0;
        #1;
        chk("fwd_A_x0", ForwardAE, 2'b00);
        clear_inputs();

        // Load-use
        tick();
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        #1;
        chk("lu_stallF", StallF, 1);
        chk("lu_stallD", StallD, 1);
        chk("lu_flushE", FlushE, 1);
        chk("lu_stallE", StallE, 0);
        chk("lu_flushD", FlushD, 0);
        tick();
        chk("lu_scnt", stall_cycles, 1);
        RdE = 0;
        #1;
        chk("lu_x0_stallF", StallF, 0);
        chk("lu_x0_flushE", FlushE, 0);
        tick();
        chk("lu_x0_scnt", stall_cycles, 1);
        clear_inputs();

        // Memory wait: three busy cycles then ready
        MemAccessM = 1; dmem_ready = 0;
        #1;
        chk("mw0_req", dmem_req, 1);
        chk("mw0_stallE", StallE, 1);
        chk("mw0_stallW", StallW, 1);
        tick();
        chk("mw1_req", dmem_req, 1);
        chk("mw1_stallM", StallM, 1);
        tick();
        chk("mw2_stallF", StallF, 1);
        tick();
        dmem_ready = 1;
        #1;
        chk("mw3_req", dmem_req, 1);
        chk("mw3_stallE", StallE, 0);
        chk("mw3_stallF", StallF, 0);
        chk("mw3_scnt", stall_cycles, 4);
        tick();
        MemAccessM = 0; dmem_ready = 0;
        #1;
        chk("mw_idle_req", dmem_req, 0);
        chk("mw_idle_scnt", stall_cycles, 4);

        // Branch during a two-cycle memory wait
        PCSrcE = 1; MemAccessM = 1; dmem_ready = 0;
        #1;
        chk("df0_flushD", FlushD, 0);
        chk("df0_flushE", FlushE, 0);
        chk("df0_stallF", StallF, 1);
        tick();
        chk("df1_flushD", FlushD, 0);
        chk("df1_flushE", FlushE, 0);
        chk("df1_fcnt", flush_events, 0);
        tick();
        dmem_ready = 1;
        #1;
        chk("df2_flushD", FlushD, 1);
        chk("df2_flushE", FlushE, 1);
        chk("df2_stallF", StallF, 0);
        tick();
        clear_inputs();
        #1;
        chk("df_fcnt", flush_events, 1);
        chk("df_scnt", stall_cycles, 6);
        chk("df_err", mem_timeout_err, 0);

        // Watchdog: memory never ready
        MemAccessM = 1; dmem_ready = 0;
        tick();
        chk("wd0_err", mem_timeout_err, 0);
        tick();
        tick();
        tick();
        chk("wd3_err", mem_timeout_err, 0);
        tick();
        chk("wd4_err", mem_timeout_err, 1);
        chk("wd4_req", dmem_req, 1);
        chk("wd4_scnt", stall_cycles, 11);
        dmem_ready = 1;
        #1;
        chk("wd_rdy_stallE", StallE, 0);
        tick();
        MemAccessM = 0; dmem_ready = 0;
        #1;
        chk("wd_sticky_err", mem_timeout_err, 1);
        chk("wd_idle_req", dmem_req, 0);

        // Reset asserted mid-WAIT, checked before any clock edge
        MemAccessM = 1;
        tick();
        tick();
        MemAccessM = 0;
        #1;
        chk("ar_wait_req", dmem_req, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_req", dmem_req, 0);
        chk("ar_err", mem_timeout_err, 0);
        chk("ar_scnt", stall_cycles, 0);
        chk("ar_fcnt", flush_events, 0);
        chk("ar_stallF", StallF, 0);
        @(negedge clk); rst = 1'b0;
        tick();
        chk("post_req", dmem_req, 0);
        chk("post_err", mem_timeout_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
